// File: rtl/ctrl_pipe_regs_if.sv
// Control-word bundle between the decode stage, the E/M/W control pipeline and its consumers.
// The slave modport is the pipeline side; the master modport is the driver/observer side.
interface ctrl_pipe_regs_if #(
  parameter int REG_AW    = 5,
  parameter int RET_CNT_W = 32
);
  logic                 FlushE;
  logic                 ValidD;
  logic                 RegWriteD;
  logic                 ALUSrcD;
  logic                 MemWriteD;
  logic [1:0]           ResultSrcD;
  logic                 BranchD;
  logic [2:0]           ALUControlD;
  logic [REG_AW-1:0]    RdD;
  logic                 ZeroE;

  logic                 RegWriteE;
  logic                 ALUSrcE;
  logic                 MemWriteE;
  logic [1:0]           ResultSrcE;
  logic                 BranchE;
  logic [2:0]           ALUControlE;
  logic [REG_AW-1:0]    RdE;
  logic                 ValidE;

  logic                 RegWriteM;
  logic                 MemWriteM;
  logic [1:0]           ResultSrcM;
  logic [REG_AW-1:0]    RdM;
  logic                 ValidM;

  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;
  logic [REG_AW-1:0]    RdW;
  logic                 ValidW;

  logic                 PCSrcE;
  logic [RET_CNT_W-1:0] RetireCnt;

  modport master (
    output FlushE, ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD,
           ALUControlD, RdD, ZeroE,
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, RdE, ValidE,
           RegWriteM, MemWriteM, ResultSrcM, RdM, ValidM,
           RegWriteW, ResultSrcW, RdW, ValidW,
           PCSrcE, RetireCnt
  );

  modport slave (
    input  FlushE, ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD,
           ALUControlD, RdD, ZeroE,
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, RdE, ValidE,
           RegWriteM, MemWriteM, ResultSrcM, RdM, ValidM,
           RegWriteW, ResultSrcW, RdW, ValidW,
           PCSrcE, RetireCnt
  );
endinterface

// File: rtl/ctrl_pipe_regs.sv
// Decode-stage control word carried through the E, M and W stages, with E-stage
// bubble insertion, branch-taken select and a retired-instruction counter.
module ctrl_pipe_regs #(
  parameter int REG_AW    = 5,
  parameter int RET_CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  ctrl_pipe_regs_if.slave bus
);

  typedef struct packed {
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              branch;
    logic [2:0]        alu_control;
    logic [REG_AW-1:0] rd;
    logic              valid;
  } e_entry_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
    logic              valid;
  } m_entry_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
    logic              valid;
  } w_entry_t;

  e_entry_t             e_d, e_q;
  m_entry_t             m_d, m_q;
  w_entry_t             w_d, w_q;
  logic [RET_CNT_W-1:0] retire_cnt_d, retire_cnt_q;

  // A flushed or non-valid D entry enters E as an all-zero bubble.
  always_comb begin
    e_d = '0;
    if (!bus.FlushE && bus.ValidD) begin
      e_d.reg_write   = bus.RegWriteD;
      e_d.alu_src     = bus.ALUSrcD;
      e_d.mem_write   = bus.MemWriteD;
      e_d.result_src  = bus.ResultSrcD;
      e_d.branch      = bus.BranchD;
      e_d.alu_control = bus.ALUControlD;
      e_d.rd          = bus.RdD;
      e_d.valid       = 1'b1;
    end
  end

  always_comb begin
    m_d            = '0;
    m_d.reg_write  = e_q.reg_write;
    m_d.mem_write  = e_q.mem_write;
    m_d.result_src = e_q.result_src;
    m_d.rd         = e_q.rd;
    m_d.valid      = e_q.valid;

    w_d            = '0;
    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
    w_d.rd         = m_q.rd;
    w_d.valid      = m_q.valid;

    retire_cnt_d = retire_cnt_q;
    if (w_q.valid) begin
      retire_cnt_d = retire_cnt_q + RET_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q          <= '0;
      m_q          <= '0;
      w_q          <= '0;
      retire_cnt_q <= '0;
    end else begin
      e_q          <= e_d;
      m_q          <= m_d;
      w_q          <= w_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.BranchE     = e_q.branch;
  assign bus.ALUControlE = e_q.alu_control;
  assign bus.RdE         = e_q.rd;
  assign bus.ValidE      = e_q.valid;

  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.ResultSrcM  = m_q.result_src;
  assign bus.RdM         = m_q.rd;
  assign bus.ValidM      = m_q.valid;

  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.ResultSrcW  = w_q.result_src;
  assign bus.RdW         = w_q.rd;
  assign bus.ValidW      = w_q.valid;

  // Taken select is combinational on the live ALU flag so fetch redirects this cycle.
  assign bus.PCSrcE    = e_q.branch & bus.ZeroE & e_q.valid;
  assign bus.RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs: a 32-bit-counter instance for the pipeline
// scenarios and a 4-bit-counter instance for counter wrap, both fed identical stimulus.
module tb_ctrl_pipe_regs;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ctrl_pipe_regs_if #(.REG_AW(5), .RET_CNT_W(32)) bus32 ();
  ctrl_pipe_regs_if #(.REG_AW(5), .RET_CNT_W(4))  bus4 ();

  ctrl_pipe_regs #(.REG_AW(5), .RET_CNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  ctrl_pipe_regs #(.REG_AW(5), .RET_CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic flush, input logic valid, input logic rw, input logic alus,
                       input logic mw, input logic [1:0] rs, input logic br,
                       input logic [2:0] aluc, input logic [4:0] rd);
    bus32.FlushE = flush; bus32.ValidD = valid; bus32.RegWriteD = rw; bus32.ALUSrcD = alus;
    bus32.MemWriteD = mw; bus32.ResultSrcD = rs; bus32.BranchD = br;
    bus32.ALUControlD = aluc; bus32.RdD = rd;
    bus4.FlushE = flush; bus4.ValidD = valid; bus4.RegWriteD = rw; bus4.ALUSrcD = alus;
    bus4.MemWriteD = mw; bus4.ResultSrcD = rs; bus4.BranchD = br;
    bus4.ALUControlD = aluc; bus4.RdD = rd;
    $display("txn t=%0t flush=%0b valid=%0b rw=%0b mw=%0b rs=%0d br=%0b rd=%0d",
             $time, flush, valid, rw, mw, rs, br, rd);
  endtask

  task automatic bubble();
    set_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bubble();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] e_vec;
    logic [8:0]  m_vec;
    logic [7:0]  w_vec;
    rst = 1'b0;
    bus32.ZeroE = 1'b1; bus4.ZeroE = 1'b1;
    set_d(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 3'd7, 5'd31);
    step(); step();
    e_vec = {bus32.RegWriteE, bus32.ALUSrcE, bus32.MemWriteE, bus32.ResultSrcE, bus32.BranchE,
             bus32.ALUControlE, bus32.RdE, bus32.ValidE};
    m_vec = {bus32.RegWriteM, bus32.MemWriteM, bus32.ResultSrcM, bus32.RdM};
    w_vec = {bus32.RegWriteW, bus32.ResultSrcW, bus32.RdW};
    if (e_vec !== 15'd0) begin bad++; $display("FAIL reset_e got=%h exp=0", e_vec); end
    total++;
    if (m_vec !== 9'd0) begin bad++; $display("FAIL reset_m got=%h exp=0", m_vec); end
    total++;
    if (w_vec !== 8'd0) begin bad++; $display("FAIL reset_w got=%h exp=0", w_vec); end
    total++;
    if ({bus32.ValidM, bus32.ValidW, bus32.PCSrcE} !== 3'b000) begin
      bad++; $display("FAIL reset_valid_pcsrc got=%b exp=000", {bus32.ValidM, bus32.ValidW, bus32.PCSrcE});
    end
    total++;
    if (bus32.RetireCnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus32.RetireCnt); end
    total++;
    bus32.ZeroE = 1'b0; bus4.ZeroE = 1'b0;
    rst = 1'b1;
    set_d(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 5'd5);
    step();
    if ({bus32.RegWriteE, bus32.RdE, bus32.ValidE} !== {1'b1, 5'd5, 1'b1}) begin
      bad++; $display("FAIL first_e got rw=%b rd=%0d v=%b exp rw=1 rd=5 v=1", bus32.RegWriteE, bus32.RdE, bus32.ValidE);
    end
    total++;
    bubble();
    step();
    if ({bus32.RegWriteM, bus32.RdM} !== {1'b1, 5'd5}) begin
      bad++; $display("FAIL first_m got rw=%b rd=%0d exp rw=1 rd=5", bus32.RegWriteM, bus32.RdM);
    end
    total++;
    step();
    if ({bus32.RegWriteW, bus32.RdW, bus32.ValidW} !== {1'b1, 5'd5, 1'b1}) begin
      bad++; $display("FAIL first_w got rw=%b rd=%0d v=%b exp rw=1 rd=5 v=1", bus32.RegWriteW, bus32.RdW, bus32.ValidW);
    end
    total++;
    step();
    if (bus32.RetireCnt !== 32'd1) begin bad++; $display("FAIL first_retire got=%0d exp=1", bus32.RetireCnt); end
    total++;
  endtask

  task automatic test_flush();
    do_reset();
    set_d(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'd2, 5'd9);
    step();
    set_d(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 3'd5, 5'd7);
    step();
    if ({bus32.ValidE, bus32.MemWriteE, bus32.BranchE, bus32.RdE, bus32.RegWriteE} !== 9'd0) begin
      bad++; $display("FAIL flush_e got v=%b mw=%b br=%b rd=%0d rw=%b exp all 0",
                      bus32.ValidE, bus32.MemWriteE, bus32.BranchE, bus32.RdE, bus32.RegWriteE);
    end
    total++;
    if ({bus32.ValidM, bus32.RdM, bus32.ResultSrcM} !== {1'b1, 5'd9, 2'd1}) begin
      bad++; $display("FAIL flush_m_untouched got v=%b rd=%0d rs=%0d exp v=1 rd=9 rs=1", bus32.ValidM, bus32.RdM, bus32.ResultSrcM);
    end
    total++;
    bubble();
    step(); step();
    if ({bus32.ValidW, bus32.RegWriteW, bus32.RdW} !== 7'd0) begin
      bad++; $display("FAIL flush_w_bubble got v=%b rw=%b rd=%0d exp 0", bus32.ValidW, bus32.RegWriteW, bus32.RdW);
    end
    total++;
    step();
    if (bus32.RetireCnt !== 32'd1) begin bad++; $display("FAIL flush_cnt got=%0d exp=1", bus32.RetireCnt); end
    total++;
  endtask

  task automatic test_branch();
    do_reset();
    set_d(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd1, 5'd0);
    step();
    bubble();
    bus32.ZeroE = 1'b1; bus4.ZeroE = 1'b1;
    #1;
    if (bus32.PCSrcE !== 1'b1) begin bad++; $display("FAIL branch_taken got=%b exp=1", bus32.PCSrcE); end
    total++;
    bus32.ZeroE = 1'b0; bus4.ZeroE = 1'b0;
    #1;
    if (bus32.PCSrcE !== 1'b0) begin bad++; $display("FAIL branch_not_taken got=%b exp=0", bus32.PCSrcE); end
    total++;
    set_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 5'd0);
    step();
    bus32.ZeroE = 1'b1; bus4.ZeroE = 1'b1;
    #1;
    if ({bus32.PCSrcE, bus32.BranchE} !== 2'b00) begin
      bad++; $display("FAIL branch_invalid got pcsrc=%b br=%b exp 0 0", bus32.PCSrcE, bus32.BranchE);
    end
    total++;
    set_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 5'd0);
    step();
    if (bus32.PCSrcE !== 1'b0) begin bad++; $display("FAIL branch_flushed got=%b exp=0", bus32.PCSrcE); end
    total++;
    bus32.ZeroE = 1'b0; bus4.ZeroE = 1'b0;
    bubble();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rs;
    do_reset();
    for (int i = 0; i <= 12; i++) begin
      if (i < 10) set_d(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'(i % 3), 1'b0, 3'd0, 5'(i + 1));
      else bubble();
      step();
      if (i >= 2 && i <= 11) begin
        exp_rs = 2'((i - 2) % 3);
        if ({bus32.ResultSrcW, bus32.RdW, bus32.ValidW} !== {exp_rs, 5'(i - 1), 1'b1}) begin
          bad++; $display("FAIL b2b_w[%0d] got rs=%0d rd=%0d v=%b exp rs=%0d rd=%0d v=1",
                          i - 2, bus32.ResultSrcW, bus32.RdW, bus32.ValidW, exp_rs, i - 1);
        end
        total++;
      end
    end
    if (bus32.ValidW !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus32.ValidW); end
    total++;
    if (bus32.RetireCnt !== 32'd10) begin bad++; $display("FAIL b2b_cnt got=%0d exp=10", bus32.RetireCnt); end
    total++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 19; i++) begin
      if (i < 17) set_d(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 5'd3);
      else bubble();
      step();
      if (i == 18 && bus4.RetireCnt !== 4'd0) begin
        bad++; $display("FAIL wrap_at16 got=%0d exp=0", bus4.RetireCnt);
      end
      if (i == 18) total++;
    end
    if (bus4.RetireCnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", bus4.RetireCnt); end
    total++;
    if (bus32.RetireCnt !== 32'd17) begin bad++; $display("FAIL wrap_wide_cnt got=%0d exp=17", bus32.RetireCnt); end
    total++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_d(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 3'd4, 5'(20 + i));
      step();
    end
    if ({bus32.ValidE, bus32.ValidM, bus32.ValidW, bus32.RetireCnt} !== {3'b111, 32'd1}) begin
      bad++; $display("FAIL midrst_pre got v=%b%b%b cnt=%0d exp v=111 cnt=1",
                      bus32.ValidE, bus32.ValidM, bus32.ValidW, bus32.RetireCnt);
    end
    total++;
    #2 rst = 1'b0;
    #1;
    if ({bus32.ValidE, bus32.ValidM, bus32.ValidW, bus32.RdW, bus32.MemWriteE, bus32.RegWriteW} !== 10'd0) begin
      bad++; $display("FAIL midrst_clear got v=%b%b%b rdw=%0d exp 0", bus32.ValidE, bus32.ValidM, bus32.ValidW, bus32.RdW);
    end
    total++;
    if (bus32.RetireCnt !== 32'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", bus32.RetireCnt); end
    total++;
    rst = 1'b1;
    bubble();
    step();
    if ({bus32.RetireCnt, bus32.ValidW} !== {32'd0, 1'b0}) begin
      bad++; $display("FAIL midrst_no_retire got cnt=%0d vw=%b exp 0 0", bus32.RetireCnt, bus32.ValidW);
    end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus32.ZeroE = 1'b0; bus4.ZeroE = 1'b0;
    bubble();
    test_reset();
    test_flush();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
